// File: rtl/priority_encoder_8to3_pkg.sv
// Shared widths and index type for the 8-to-3 priority encoder.
package priority_encoder_8to3_pkg;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/priority_encoder_8to3_core.sv
// Combinational priority logic: index of the highest set request bit plus a valid flag.
module priority_encoder_8to3_core
    import priority_encoder_8to3_pkg::*;
(
    input  logic [IN_W-1:0]  D,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    idx_t idx_c;

    // Ascending scan: a higher set bit overwrites any lower one, so unknown
    // lower bits never decide the result once a higher bit is set.
    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (D[i]) begin
                idx_c = idx_t'(i);
            end
        end
    end

    assign idx   = idx_c;
    assign valid = |D;

endmodule

// File: rtl/priority_encoder_8to3.sv
// 8-to-3 priority encoder with an optional output register stage (OUT_REG).
module priority_encoder_8to3
    import priority_encoder_8to3_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] D,
    output logic            A,
    output logic            B,
    output logic            C,
    output logic            V
);

    idx_t idx_c;
    logic valid_c;

    priority_encoder_8to3_core u_core (
        .D     (D),
        .idx   (idx_c),
        .valid (valid_c)
    );

    generate
        if (OUT_REG != 0) begin : g_reg
            idx_t idx_q;
            logic valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    idx_q   <= idx_c;
                    valid_q <= valid_c;
                end
            end

            assign {A, B, C} = idx_q;
            assign V         = valid_q;
        end else begin : g_comb
            assign {A, B, C} = idx_c;
            assign V         = valid_c;
        end
    endgenerate

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench: registered and combinational instances against an arithmetic reference model.
module tb_priority_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] D;
    logic       a_r, b_r, c_r, v_r;
    logic       a_c, b_c, c_c, v_c;

    int unsigned errors = 0;
    int unsigned checks = 0;

    priority_encoder_8to3 #(.OUT_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .A     (a_r),
        .B     (b_r),
        .C     (c_r),
        .V     (v_r)
    );

    priority_encoder_8to3 #(.OUT_REG(0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .A     (a_c),
        .B     (b_c),
        .C     (c_c),
        .V     (v_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {A,B,C,V}: index is floor(log2(d)) for nonzero d.
    function automatic logic [3:0] model(input logic [7:0] d);
        int unsigned n;
        if (d == 8'h00) return 4'b0000;
        n = $clog2(int'(d) + 1) - 1;
        return {3'(n), 1'b1};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ABCV=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] obs_r();
        return {a_r, b_r, c_r, v_r};
    endfunction

    function automatic logic [3:0] obs_c();
        return {a_c, b_c, c_c, v_c};
    endfunction

    // Apply at negedge, check combinational path, then registered path after next edge.
    task automatic apply(input string tag, input logic [7:0] d, input logic [3:0] exp);
        @(negedge clk);
        D = d;
        #1;
        check({tag, "_comb"}, obs_c(), exp);
        @(posedge clk);
        #1;
        check({tag, "_reg"}, obs_r(), exp);
    endtask

    logic [7:0] vec [9] = '{8'b00000000, 8'b10101010, 8'b01011000, 8'b00101010,
                            8'b00010100, 8'b00001110, 8'b00000101, 8'b00000011,
                            8'b00000001};
    logic [3:0] want [9] = '{4'b0000, 4'b1111, 4'b1101, 4'b1011,
                             4'b1001, 4'b0111, 4'b0101, 4'b0011,
                             4'b0001};

    initial begin
        rst_n = 1'b0;
        D     = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", obs_r(), 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", obs_r(), 4'b0000);
        @(posedge clk);
        #1;
        check("first_after_release", obs_r(), 4'b1111);

        for (int i = 0; i < 9; i++) begin
            check($sformatf("table%0d_model", i), model(vec[i]), want[i]);
            apply($sformatf("table%0d", i), vec[i], want[i]);
        end

        // Latency: registered output must not move before the capturing edge.
        apply("lat_pre", 8'h01, 4'b0001);
        @(negedge clk);
        D = 8'h80;
        #1;
        check("lat_before_edge", obs_r(), 4'b0001);
        check("lat_comb", obs_c(), 4'b1111);
        @(posedge clk);
        #1;
        check("lat_after_edge", obs_r(), 4'b1111);

        // Asynchronous reset between edges, then release.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs_r(), 4'b0000);
        @(posedge clk);
        #1;
        check("reset_edge_held", obs_r(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("no_stale", obs_r(), 4'b0000);
        @(posedge clk);
        #1;
        check("reset_recover", obs_r(), 4'b1111);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (i % 4 == 0) d = d >> $urandom_range(0, 7);
            apply("rand", d, model(d));
        end

        // Unknown bits below the highest set bit must not matter.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            int unsigned k;
            k = $urandom_range(0, 7);
            d = 8'bxxxxxxxx;
            d[k] = 1'b1;
            for (int unsigned j = k + 1; j < 8; j++) d[j] = 1'b0;
            apply("xlow", d, {3'(k), 1'b1});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
